apb_master_cmd: RTL and testbench

Parametrised APB master that turns a valid/ready command stream (read/write, address, data, byte strobes) into APB3/APB4 transfers, and returns a one-pulse response carrying read data and error status.
- Successor to the fixed-address, fixed-width APB master: generalised in address and data width.
- Adds command handshaking, byte strobes, PSLVERR reporting and back-to-back transfers.
- Sits between an internal requester (CSR sequencer or test engine) and the APB peripheral fabric.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_timeout_cnt.sv | 30 +++
 rtl/apb_master_cmd.sv | 138 +++++++++++++
 tb/tb_apb_master_cmd.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB command master: FSM encoding, default-width command record, legal widths.
// Widths in apb_cmd_t follow the package defaults; parametrised users size their own registers.
package apb_pkg;

  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_STRB_W = PKG_DATA_W / 8;

  // One bit per legal data width: 8, 16 and 32.
  localparam logic [32:0] LEGAL_DATA_W = 33'h1_0001_0100;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] wdata;
    logic [PKG_STRB_W-1:0] strb;
  } apb_cmd_t;

  function automatic bit data_w_legal(input int w);
    return (w >= 0 && w <= 32) ? bit'(LEGAL_DATA_W[w]) : 1'b0;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS wait counter: clr wins over en, expired is high once the count sits at LIMIT-1.
// Zero latency on expired (combinational compare of the registered count); no backpressure.
module apb_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic pclk_i,
  input  logic prst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge pclk_i) begin
    if (!prst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/apb_master_cmd.sv
// APB3/4 master: valid/ready command in, one-cycle response out; accept at N -> SETUP N+1, ACCESS N+2, rsp N+3+waits.
// cmd_ready only in IDLE or a completing ACCESS (back-to-back); responses have no backpressure. Optional APB_TIMEOUT_EN aborts stuck ACCESS.
module apb_master_cmd
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STRB_W         = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              pclk_i,
  input  logic              prst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [STRB_W-1:0] cmd_strb_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  output logic [STRB_W-1:0] pstrb_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("apb_master_cmd: DATA_W=%0d must be 8, 16 or 32", DATA_W);
  end
  if (ADDR_W < 8 || ADDR_W > 32) begin : g_bad_addr_w
    $error("apb_master_cmd: ADDR_W=%0d must be within 8..32", ADDR_W);
  end
  if (STRB_W != DATA_W / 8) begin : g_bad_strb_w
    $error("apb_master_cmd: STRB_W=%0d must equal DATA_W/8", STRB_W);
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_cmd: TIMEOUT_CYCLES=%0d must be at least 1", TIMEOUT_CYCLES);
  end

  apb_state_t state_q;
  logic       cmd_accept;
  logic       timeout_abort;

  // Gated by prst_n so the handshake is closed for the whole reset window.
  assign cmd_ready_o = prst_n && ((state_q == IDLE) || ((state_q == ACCESS) && pready_i));
  assign cmd_accept  = cmd_valid_i && cmd_ready_o;

`ifdef APB_TIMEOUT_EN
  logic to_expired;

  apb_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .pclk_i (pclk_i),
    .prst_n (prst_n),
    .clr    (state_q == SETUP),
    .en     ((state_q == ACCESS) && !pready_i),
    .expired(to_expired)
  );

  // pready_i has priority: a completion in the limit cycle is a normal completion.
  assign timeout_abort = (state_q == ACCESS) && !pready_i && to_expired;
`else
  assign timeout_abort = 1'b0;
`endif

  always_ff @(posedge pclk_i) begin
    if (!prst_n) begin
      state_q     <= IDLE;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      paddr_o     <= '0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;

      // Command registers drive the bus and only change on acceptance.
      if (cmd_accept) begin
        paddr_o  <= cmd_addr_i;
        pwrite_o <= cmd_write_i;
        pwdata_o <= cmd_write_i ? cmd_wdata_i : '0;
        pstrb_o  <= cmd_write_i ? cmd_strb_i : '0;
      end

      case (state_q)
        IDLE: begin
          if (cmd_accept) begin
            state_q   <= SETUP;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: begin
          if (pready_i) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
            rsp_err_o   <= pslverr_i;
            penable_o   <= 1'b0;
            if (cmd_accept) begin
              state_q <= SETUP;
            end else begin
              state_q <= IDLE;
              psel_o  <= 1'b0;
            end
          end else if (timeout_abort) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            state_q     <= IDLE;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_cmd.sv
// Randomised bench for apb_master_cmd: transaction-level model of latency, bus contents and responses.
// Drives and samples on the falling edge; APB_TIMEOUT_EN adds abort and limit-boundary transfers.
module tb_apb_master_cmd;

  localparam int TO    = 8;
  localparam int NTX   = 300;
  localparam int LIMIT = 40000;

  logic        clk = 1'b0;
  logic        prst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  apb_master_cmd #(
    .ADDR_W(32), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk_i(clk), .prst_n(prst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] prdata;
    logic        err;
    int          w;
    int          acc;
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  xfer_t pend[$];
  rsp_t  rsp_q[$];
  xfer_t cur;
  xfer_t nxt;
  rsp_t  r;
  logic  cur_vld = 1'b0;
  logic  nxt_vld = 1'b0;
  logic  prev_setup = 1'b0;
  logic [31:0] last_rdata = '0;
  logic  last_err = 1'b0;
  int    acc_cnt = 0;
  int    n_gen = 0;
  int    n_mid = 0;
  int    rst_hold = 3;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_bus(input string tag);
    chk({tag, "_ctl"}, {pwrite_o, pstrb_o, paddr_o}, {cur.wr, cur.wr ? cur.strb : 4'h0, cur.addr});
    chk({tag, "_wdata"}, {32'h0, pwdata_o}, {32'h0, cur.wr ? cur.wdata : 32'h0});
  endtask

  function automatic xfer_t gen_xfer(input int idx);
    xfer_t x;
    x.wr     = 1'($urandom_range(0, 1));
    x.addr   = $urandom;
    x.wdata  = $urandom;
    x.strb   = 4'($urandom);
    x.prdata = $urandom;
    x.err    = ($urandom_range(0, 3) == 0);
    x.w      = $urandom_range(0, 3);
    x.acc    = 0;
`ifdef APB_TIMEOUT_EN
    case ($urandom_range(0, 15))
      0: x.w = 20;
      1: x.w = TO - 1;
      default: ;
    endcase
`endif
    case (idx)
      0: begin x.wr = 1'b0; x.addr = 32'h40; x.w = 0; x.prdata = 32'h1234_5678; x.err = 1'b0; end
      1: begin x.wr = 1'b1; x.addr = 32'h44; x.wdata = 32'hA5A5_0001; x.strb = 4'b0011; x.w = 3; x.err = 1'b0; end
      2: begin x.wr = 1'b0; x.addr = 32'h48; x.w = 0; x.err = 1'b1; end
      3: begin x.wr = 1'b0; x.addr = 32'h4C; x.w = 2; x.err = 1'b0; end
`ifdef APB_TIMEOUT_EN
      4: begin x.wr = 1'b1; x.addr = 32'h50; x.w = 20; end
      5: begin x.wr = 1'b0; x.addr = 32'h54; x.w = TO - 1; x.err = 1'b0; end
`endif
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    prst_n = 1'b0; cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = '0;
    cmd_wdata_i = '0; cmd_strb_i = '0; prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;

    while (!(n_gen >= NTX && !nxt_vld && pend.size() == 0 && rsp_q.size() == 0 && !cur_vld && prst_n)
           && cyc < LIMIT) begin
      @(negedge clk);
      // ---- observe the cycle that just started ----
      if (!prst_n) begin
        chk("rst_ctl", {cmd_ready_o, rsp_valid_o, rsp_err_o, psel_o, penable_o, pwrite_o, pstrb_o}, 64'h0);
        chk("rst_data", {rsp_rdata_o, paddr_o}, 64'h0);
        chk("rst_wdata", {32'h0, pwdata_o}, 64'h0);
        last_rdata = '0; last_err = 1'b0; prev_setup = 1'b0; cur_vld = 1'b0;
      end else begin
        if (rsp_valid_o) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            r = rsp_q.pop_front();
            chk("rsp_cyc", cyc, r.cyc);
            chk("rsp_rdata", rsp_rdata_o, r.rdata);
            chk("rsp_err", rsp_err_o, r.err);
            last_rdata = r.rdata; last_err = r.err;
          end
        end else begin
          chk("rsp_hold", {rsp_err_o, rsp_rdata_o}, {last_err, last_rdata});
          if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
            chk("rsp_missing", 0, 1);
            void'(rsp_q.pop_front());
          end
        end
        if (prev_setup) chk("access_after_setup", {psel_o, penable_o}, 2'b11);
        if (psel_o && !penable_o) begin
          if (pend.size() == 0) begin chk("setup_unexpected", 1, 0); cur_vld = 1'b0; end
          else begin
            cur = pend.pop_front(); cur_vld = 1'b1; acc_cnt = 0;
            chk("setup_cyc", cyc, cur.acc + 1);
            chk_bus("setup");
          end
        end else if (psel_o && penable_o) begin
          if (!cur_vld) chk("access_unexpected", 1, 0);
          else chk_bus("access");
        end else begin
          chk("penable_no_psel", penable_o, 0);
        end
        prev_setup = psel_o && !penable_o;
      end

      // ---- drive inputs for the next edge ----
      if (rst_hold == 0 && n_mid < 3 && n_gen > 20 && prst_n && psel_o && penable_o
          && $urandom_range(0, 99) < 3) begin
        rst_hold = 2; n_mid++;
      end
      if (rst_hold > 0) begin
        rst_hold--;
        prst_n = 1'b0; pready_i = 1'b0; prdata_i = $urandom; pslverr_i = 1'b1;
        pend.delete(); rsp_q.delete(); cur_vld = 1'b0; prev_setup = 1'b0;
      end else begin
        prst_n = 1'b1;
        if (psel_o && penable_o && cur_vld) begin
          if (acc_cnt == cur.w) begin
            pready_i = 1'b1; prdata_i = cur.prdata; pslverr_i = cur.err; cur_vld = 1'b0;
          end else begin
            pready_i = 1'b0; prdata_i = $urandom; pslverr_i = 1'b1;
`ifdef APB_TIMEOUT_EN
            if (acc_cnt == TO - 1) cur_vld = 1'b0;
`endif
          end
          acc_cnt++;
        end else begin
          pready_i = 1'($urandom_range(0, 1)); prdata_i = $urandom; pslverr_i = 1'($urandom_range(0, 1));
        end
      end
      if (!nxt_vld && n_gen < NTX && (n_gen < 6 || !prst_n || $urandom_range(0, 9) < 7)) begin
        nxt = gen_xfer(n_gen); nxt_vld = 1'b1; n_gen++;
      end
      cmd_valid_i = nxt_vld;
      cmd_write_i = nxt_vld ? nxt.wr : 1'($urandom_range(0, 1));
      cmd_addr_i  = nxt_vld ? nxt.addr : $urandom;
      cmd_wdata_i = nxt_vld ? nxt.wdata : $urandom;
      cmd_strb_i  = nxt_vld ? nxt.strb : 4'($urandom);

      #1;
      chk("cmd_ready", cmd_ready_o, prst_n && (!psel_o || (penable_o && pready_i)));
      if (cmd_valid_i && cmd_ready_o) begin
        nxt.acc = cyc;
        pend.push_back(nxt);
`ifdef APB_TIMEOUT_EN
        if (nxt.w > TO - 1) begin
          r.rdata = '0; r.err = 1'b1; r.cyc = cyc + 2 + TO;
        end else
`endif
        begin
          r.rdata = nxt.wr ? 32'h0 : nxt.prdata; r.err = nxt.err; r.cyc = cyc + 3 + nxt.w;
        end
        rsp_q.push_back(r);
        nxt_vld = 1'b0;
      end
    end

    chk("drain_within_budget", (cyc < LIMIT) ? 1 : 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
